ethernet_rx_framer: RTL and testbench



---
 rtl/ethernet_pkg.sv | 25 ++
 rtl/ethernet_crc32.sv | 26 ++
 rtl/ethernet_rx_framer.sv | 149 ++++++++++++++
 tb/tb_ethernet_rx_framer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ethernet_pkg.sv
// Shared constants, FSM state encoding and the byte-wide CRC-32 step used by the RX framer.
package ethernet_pkg;
  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DISCARD
  } state_e;

  // Reflected CRC-32, one byte LSB-first; no final inversion, so a good frame leaves the residue.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction
endpackage

// File: rtl/ethernet_crc32.sv
// Byte-wide CRC-32 register: init reloads the seed, en folds one byte in (init wins).
module ethernet_crc32
  import ethernet_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC_INIT;
    else if (en) crc_d = crc32_byte(crc_q, data);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/ethernet_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, emits valid/last bytes and counts frames.
// ETHERNET_RX_FCS_STRIP_EN selects a 5-byte delay buffer so the FCS never reaches the output.
module ethernet_rx_framer
  import ethernet_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  input  logic        io_rx_error,
  output logic        io_out_valid,
  output logic [7:0]  io_out_data,
  output logic        io_out_last,
  output logic        io_out_error,
  output logic [15:0] io_stat_good,
  output logic [15:0] io_stat_bad
);
`ifdef ETHERNET_RX_FCS_STRIP_EN
  localparam int DEPTH = 5;
`else
  localparam int DEPTH = 1;
`endif
  localparam int NW = $clog2(MAX_FRAME + 2);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] N_SAT = NW'(MAX_FRAME + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  state_e                 state_q, state_d;
  logic [NW-1:0]          len_q, len_d;
  logic                   err_q, err_d;
  logic [DEPTH-1:0][7:0]  buf_q, buf_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   out_error_q, out_error_d;
  logic [15:0]            good_q, good_d;
  logic [15:0]            bad_q, bad_d;
  logic [31:0]            crc;
  logic                   take, frame_end, frame_bad;

  assign take      = (state_q == ST_DATA) && io_rx_valid;
  assign frame_end = (state_q == ST_DATA) && !io_rx_valid;

  ethernet_crc32 u_crc (
    .clock (clock),
    .reset (reset),
    .init  (!take),
    .en    (take),
    .data  (io_rx_data),
    .crc   (crc)
  );

  assign frame_bad = err_q || (crc != CRC_RESIDUE) ||
                     (len_q < NW'(MIN_FRAME)) || (len_q > NW'(MAX_FRAME));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (io_rx_valid) begin
          if (io_rx_data == PREAMBLE) state_d = ST_PREAMBLE;
          else if (io_rx_data == SFD) state_d = ST_DATA;
          else                        state_d = ST_DISCARD;
        end
      end
      ST_PREAMBLE: begin
        if (!io_rx_valid)                state_d = ST_IDLE;
        else if (io_rx_data == SFD)      state_d = ST_DATA;
        else if (io_rx_data != PREAMBLE) state_d = ST_DISCARD;
      end
      ST_DATA:    if (!io_rx_valid) state_d = ST_IDLE;
      ST_DISCARD: if (!io_rx_valid) state_d = ST_IDLE;
      default:    state_d = ST_DISCARD;
    endcase
  end

  always_comb begin
    len_d       = '0;
    err_d       = 1'b0;
    buf_d       = buf_q;
    cnt_d       = '0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    out_error_d = 1'b0;
    good_d      = good_q;
    bad_d       = bad_q;
    if (take) begin
      len_d    = (len_q == N_SAT) ? len_q : len_q + 1'b1;
      err_d    = err_q | io_rx_error;
      buf_d[0] = io_rx_data;
      for (int i = 1; i < DEPTH; i++) buf_d[i] = buf_q[i-1];
      cnt_d    = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
      if (cnt_q == FULL) begin
        out_valid_d = 1'b1;
        out_data_d  = buf_q[DEPTH-1];
      end
    end else if (frame_end) begin
      // Only the oldest buffered byte survives; the younger ones are the FCS tail (or nothing to emit).
      if (cnt_q == FULL) begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_error_d = frame_bad;
        out_data_d  = buf_q[DEPTH-1];
      end
      if ((cnt_q == FULL) && !frame_bad) good_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
      else                               bad_d  = (bad_q  == 16'hFFFF) ? bad_q  : bad_q  + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_DISCARD;
      len_q       <= '0;
      err_q       <= 1'b0;
      buf_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_error_q <= 1'b0;
      good_q      <= '0;
      bad_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      err_q       <= err_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_error_q <= out_error_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out_data  = out_data_q;
  assign io_out_last  = out_last_q;
  assign io_out_error = out_error_q;
  assign io_stat_good = good_q;
  assign io_stat_bad  = bad_q;
endmodule

// File: tb/tb_ethernet_rx_framer.sv
// Scoreboard bench for ethernet_rx_framer: stimulus pushes expected output bytes, a monitor pops and compares.
module tb_ethernet_rx_framer;
`ifdef ETHERNET_RX_FCS_STRIP_EN
  localparam int D     = 5;
  localparam bit STRIP = 1'b1;
`else
  localparam int D     = 1;
  localparam bit STRIP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_error = 1'b0;
  logic        out_valid, out_last, out_error;
  logic [7:0]  out_data;
  logic [15:0] stat_good, stat_bad;

  always #4 clock = ~clock;

  ethernet_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_rx_data   (rx_data),
    .io_rx_valid  (rx_valid),
    .io_rx_error  (rx_error),
    .io_out_valid (out_valid),
    .io_out_data  (out_data),
    .io_out_last  (out_last),
    .io_out_error (out_error),
    .io_stat_good (stat_good),
    .io_stat_bad  (stat_bad)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frm[$];
  int checks = 0, failures = 0;
  int exp_good = 0, exp_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got data %02h last %0b err %0b, expected no output",
                 out_data, out_last, out_error);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", {24'h0, out_data}, {24'h0, e.d});
        chk("out_last", {31'h0, out_last}, {31'h0, e.l});
        chk("out_error", {31'h0, out_error}, {31'h0, e.e});
      end
    end
  end

  // Frame = payload + FCS, FCS computed bit-serially and sent low byte first.
  task automatic build(input int plen, input int seed, input bit good_fcs);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      b = 8'(i * 13 + seed);
      frm.push_back(b);
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    if (!good_fcs) c[7:0] = ~c[7:0];
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  task automatic expect_frame(input bit err);
    int n, nout;
    exp_t e;
    n    = frm.size();
    nout = STRIP ? n - 4 : n;
    for (int k = 0; k < nout; k++) begin
      e.d = frm[k];
      e.l = (k == nout - 1);
      e.e = (k == nout - 1) && err;
      exp_q.push_back(e);
    end
    if (nout > 0 && !err) exp_good++;
    else                  exp_bad++;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    rx_valid = v;
    rx_data  = d;
    rx_error = e;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int pre, input int er_idx, input int gap);
    for (int i = 0; i < pre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], i == er_idx);
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_counters(input string name);
    chk({name, "_good"}, {16'h0, stat_good}, 32'(exp_good));
    chk({name, "_bad"},  {16'h0, stat_bad},  32'(exp_bad));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_last",  {31'h0, out_last},  32'h0);
    chk("rst_error", {31'h0, out_error}, 32'h0);
    chk("rst_data",  {24'h0, out_data},  32'h0);
    check_counters("rst");
    reset = 1'b0;
    repeat (2) drive(1'b0, 8'h00, 1'b0);

    build(60, 1, 1'b1); expect_frame(1'b0); send(7, -1, 4); check_counters("good");
    build(60, 1, 1'b0); expect_frame(1'b1); send(7, -1, 4); check_counters("bad_fcs");
    build(60, 5, 1'b1); expect_frame(1'b1); send(7, 20, 4); check_counters("rx_er");
    build(36, 9, 1'b1); expect_frame(1'b1); send(7, -1, 4); check_counters("runt");

    frm.delete();
    frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
    expect_frame(1'b1); send(2, -1, 4); check_counters("tiny");

    build(60, 2, 1'b1); expect_frame(1'b0); send(7, -1, 1);
    build(70, 3, 1'b1); expect_frame(1'b0); send(3, -1, 4); check_counters("b2b");

    // Interrupted frame: only bytes fully visible before reset are expected, never a last.
    build(60, 4, 1'b1);
    for (int k = 0; k <= 30 - 2 - D; k++) begin
      e.d = frm[k]; e.l = 1'b0; e.e = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b1, frm[i], 1'b0);
    reset = 1'b1;
    #1;
    exp_good = 0;
    exp_bad  = 0;
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_last",  {31'h0, out_last},  32'h0);
    check_counters("midrst");

    // Reset released partway through a frame: that frame must be ignored.
    repeat (2) drive(1'b0, 8'h00, 1'b0);
    build(60, 6, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, frm[i], 1'b0);
    reset = 1'b0;
    for (int i = 10; i < frm.size(); i++) drive(1'b1, frm[i], 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b0);
    check_counters("ignored");

    build(60, 7, 1'b1); expect_frame(1'b0); send(7, -1, 4); check_counters("after_rst");

    repeat (10) drive(1'b0, 8'h00, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
